// File: rtl/vga_term_pkg.sv
// rtl/vga_term_pkg.sv - shared state encoding and ASCII constants for the terminal writer
package vga_term_pkg;

  typedef enum logic [1:0] {
    INIT_CLR,
    IDLE,
    SCROLL_CLR
  } state_t;

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_SPACE = 8'h20;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_term_writer_if.sv
// rtl/vga_term_writer_if.sv - character input handshake plus character-RAM write port
interface vga_term_writer_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_char;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // master is the writer itself; slave is the producer / RAM side
  modport master (
    input  in_valid, in_char,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_char,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/vga_term_addr.sv
// rtl/vga_term_addr.sv - maps logical (row, col) through the scroll base to a RAM address
module vga_term_addr #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic [4:0]        row,
  input  logic [6:0]        col,
  input  logic [4:0]        base,
  output logic [ADDR_W-1:0] addr
);
  logic [5:0] sum;
  logic [4:0] phys;

  // base and row are both below ROWS, so a single conditional subtract is the modulo
  always_comb begin
    sum  = {1'b0, row} + {1'b0, base};
    phys = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
    addr = ADDR_W'(phys) * ADDR_W'(COLS) + ADDR_W'(col);
  end
endmodule

// File: rtl/vga_term_writer.sv
// rtl/vga_term_writer.sv - text terminal writer into a scrolling character RAM (optional VGA_TERM_BS_EN)
module vga_term_writer
  import vga_term_pkg::*;
#(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic               pclk,
  input  logic               rst,
  vga_term_writer_if.master  bus,
  output logic [4:0]         cursor_row,
  output logic [6:0]         cursor_col,
  output logic [4:0]         scroll_base
);
  localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [6:0]        COL_MAX   = 7'(COLS - 1);
  localparam logic [4:0]        ROW_MAX   = 5'(ROWS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              ready, accept, is_print, is_lf, is_cr, is_bs;
  logic              newline, need_scroll;
  logic [6:0]        wr_col;
  logic [ADDR_W-1:0] cur_addr, clr_addr;

  always_comb begin
    accept   = bus.in_valid && ready;
    is_print = is_printable(bus.in_char);
    is_lf    = (bus.in_char == CH_LF);
    is_cr    = (bus.in_char == CH_CR);
`ifdef VGA_TERM_BS_EN
    is_bs    = (bus.in_char == CH_BS);
`else
    is_bs    = 1'b0;
`endif
    // backspace writes at the column it moves to; everything else at the current column
    wr_col      = (is_bs && cursor_col != 7'd0) ? cursor_col - 7'd1 : cursor_col;
    newline     = accept && (is_lf || (is_print && cursor_col == COL_MAX));
    need_scroll = newline && (cursor_row == ROW_MAX);
  end

  vga_term_addr #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cur_addr (
    .row (cursor_row),
    .col (wr_col),
    .base(scroll_base),
    .addr(cur_addr)
  );

  // scroll_base has already advanced, so logical bottom row is the freshly exposed one
  vga_term_addr #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_clr_addr (
    .row (ROW_MAX),
    .col (clr_cnt[6:0]),
    .base(scroll_base),
    .addr(clr_addr)
  );

  always_ff @(posedge pclk) begin
    if (rst) state <= INIT_CLR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT_CLR:   if (clr_cnt == LAST_INIT) state_nx = IDLE;
      IDLE:       if (need_scroll)          state_nx = SCROLL_CLR;
      SCROLL_CLR: if (clr_cnt == LAST_COL)  state_nx = IDLE;
      default:                              state_nx = INIT_CLR;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      clr_cnt     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cursor_row  <= '0;
      cursor_col  <= '0;
      scroll_base <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        INIT_CLR, SCROLL_CLR: begin
          wr_en_q   <= 1'b1;
          wr_data_q <= CH_SPACE;
          wr_addr_q <= (state == INIT_CLR) ? clr_cnt : clr_addr;
          clr_cnt   <= (state_nx != state) ? '0 : clr_cnt + 1'b1;
        end
        IDLE: if (accept) begin
          if (is_print || is_bs) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cur_addr;
            wr_data_q <= is_bs ? CH_SPACE : bus.in_char;
          end
          if (is_print && cursor_col != COL_MAX) cursor_col <= cursor_col + 7'd1;
          else if (is_bs)                        cursor_col <= wr_col;
          else if (is_print || is_lf || is_cr)   cursor_col <= '0;
          if (newline && cursor_row != ROW_MAX)  cursor_row <= cursor_row + 5'd1;
          if (need_scroll) begin
            scroll_base <= (scroll_base == ROW_MAX) ? 5'd0 : scroll_base + 5'd1;
            clr_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
endmodule

// File: tb/tb_vga_term_writer.sv
// tb/tb_vga_term_writer.sv - directed scoreboard bench for vga_term_writer
module tb_vga_term_writer;
  localparam int COLS = 70;
  localparam int ROWS = 30;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic [4:0] cursor_row, scroll_base;
  logic [6:0] cursor_col;

  vga_term_writer_if #(.ADDR_W(12)) bus ();

  vga_term_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
    .pclk       (pclk),
    .rst        (rst),
    .bus        (bus),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .scroll_base(scroll_base)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0, errors = 0;
  int  wr_count = 0, cyc = 0, last_wr_cyc = 0, prev_wr_cyc = 0;
  int  mrow = 0, mcol = 0, mbase = 0;
  int  w0, n;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (bus.wr_en !== 1'b0) begin
      wr_count++;
      prev_wr_cyc = last_wr_cyc;
      last_wr_cyc = cyc;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL wr_unexpected observed addr=%0h data=%0h expected no write", bus.wr_addr, bus.wr_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
      end
    end
  end

  function automatic logic [11:0] maddr(input int r, input int c);
    return 12'(((mbase + r) % ROWS) * COLS + c);
  endfunction

  task automatic model_newline();
    if (mrow < ROWS - 1) mrow++;
    else begin
      mbase = (mbase + 1) % ROWS;
      for (int i = 0; i < COLS; i++) exp_q.push_back('{addr: maddr(ROWS - 1, i), data: 8'h20});
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back('{addr: maddr(mrow, mcol), data: c});
      if (mcol == COLS - 1) begin
        mcol = 0;
        model_newline();
      end else mcol++;
    end else if (c == 8'h0A) begin
      mcol = 0;
      model_newline();
    end else if (c == 8'h0D) mcol = 0;
`ifdef VGA_TERM_BS_EN
    else if (c == 8'h08) begin
      if (mcol > 0) mcol--;
      exp_q.push_back('{addr: maddr(mrow, mcol), data: 8'h20});
    end
`endif
  endtask

  task automatic send(input logic [7:0] c);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (bus.in_ready !== 1'b1 && k < 500) begin
      @(posedge pclk); #1;
      k++;
    end
    check("send_ready_wait", 32'(k < 500), 32'd1);
    model_char(c);
    @(posedge pclk); #1;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge pclk); #1;
      k++;
    end
    repeat (2) @(posedge pclk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_cursor(input string tag, input int r, input int c, input int b);
    check({tag, "_row"},  32'(cursor_row),  32'(r));
    check({tag, "_col"},  32'(cursor_col),  32'(c));
    check({tag, "_base"}, 32'(scroll_base), 32'(b));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check_cursor(tag, 0, 0, 0);
  endtask

  task automatic run_init(input string tag);
    int k = 0;
    int w = wr_count;
    mrow = 0; mcol = 0; mbase = 0;
    for (int i = 0; i < COLS * ROWS; i++) exp_q.push_back('{addr: 12'(i), data: 8'h20});
    rst = 1'b0;
    while (bus.in_ready !== 1'b1 && k < 3000) begin
      @(posedge pclk); #1;
      k++;
    end
    check({tag, "_init_cycles"}, 32'(k), 32'd2100);
    drain({tag, "_init_drain"});
    check({tag, "_init_writes"}, 32'(wr_count - w), 32'd2100);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    check_cursor({tag, "_init"}, 0, 0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_reset("rst");
    run_init("first");

    w0 = wr_count;
    send(8'h41);
    send(8'h42);
    drain("ab_drain");
    check("ab_writes", 32'(wr_count - w0), 32'd2);
    check("ab_consecutive", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
    check_cursor("ab", 0, 2, 0);

    send(8'h0D);
    w0 = wr_count;
    send(8'h78);
    send(8'h0D);
    send(8'h0A);
    drain("xcrlf_drain");
    check("xcrlf_writes", 32'(wr_count - w0), 32'd1);
    check_cursor("xcrlf", 1, 0, 0);

    w0 = wr_count;
    send(8'h01);
    drain("other_drain");
    check("other_writes", 32'(wr_count - w0), 32'd0);
    check_cursor("other", 1, 0, 0);

    repeat (28) send(8'h0A);
    for (int i = 0; i < 69; i++) send(8'h61 + 8'(i % 26));
    drain("corner_drain");
    check_cursor("corner", 29, 69, 0);

    send(8'h5A);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 500) begin
      @(posedge pclk); #1;
      n++;
    end
    check("scroll_ready_low", 32'(n), 32'd70);
    drain("scroll_drain");
    check_cursor("scroll", 29, 0, 1);

    send(8'h0A);
    repeat (29) @(posedge pclk);
    #1;
    check("midscroll_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge pclk); #1;
    exp_q.delete();
    repeat (2) @(posedge pclk);
    #1;
    check_reset("midscroll_rst");
    run_init("second");

    send(8'h68); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
    drain("hello_drain");
    check_cursor("hello", 0, 5, 0);
    w0 = wr_count;
    send(8'h08);
    drain("bs_drain");
`ifdef VGA_TERM_BS_EN
    check("bs_writes", 32'(wr_count - w0), 32'd1);
    check_cursor("bs", 0, 4, 0);
`else
    check("bs_writes", 32'(wr_count - w0), 32'd0);
    check_cursor("bs", 0, 5, 0);
`endif
    send(8'h0D);
    w0 = wr_count;
    send(8'h08);
    drain("bs0_drain");
`ifdef VGA_TERM_BS_EN
    check("bs0_writes", 32'(wr_count - w0), 32'd1);
`else
    check("bs0_writes", 32'(wr_count - w0), 32'd0);
`endif
    check_cursor("bs0", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_term_writer.md
VGA_TERM_WRITER -- requirements
Module: vga_term_writer

Interface
REQ-001 Parameter COLS, default 70, sets the number of text columns per row.
REQ-002 Parameter ROWS, default 30, sets the number of text rows on screen.
REQ-003 Parameter ADDR_W, default 12, is the character-RAM address width; COLS*ROWS SHALL be at most 2**ADDR_W.
REQ-004 Port pclk, input, 1, is the single clock; the block SHALL have one clock, and reset is synchronous and active-high.
REQ-005 Port rst, input, 1, is a synchronous active-high reset sampled on the pclk rising edge.
REQ-006 Port in_valid, input, 1, indicates that in_char holds a character offered by the producer.
REQ-007 Port in_char, input, 8, carries the ASCII code.
REQ-008 Port in_ready, output, 1, indicates the writer accepts in_char this cycle.
REQ-009 Port wr_en, output, 1, is the character-RAM write strobe.
REQ-010 Port wr_addr, output, ADDR_W, is the character-RAM write address.
REQ-011 Port wr_data, output, 8, is the character-RAM write data.
REQ-012 Port cursor_row, output, 5, gives the logical cursor row in the range 0..ROWS-1.
REQ-013 Port cursor_col, output, 7, gives the cursor column in the range 0..COLS-1.
REQ-014 Port scroll_base, output, 5, is the physical RAM row shown as screen row 0; the renderer adds it mod ROWS.

Function
REQ-015 A transfer SHALL occur on a pclk edge where in_valid and in_ready are both high; in_char is ignored on any other edge.
REQ-016 The FSM SHALL have three states: INIT_CLR, IDLE and SCROLL_CLR; in_ready SHALL be high only in IDLE.
REQ-017 The physical row SHALL be (scroll_base + cursor_row) mod ROWS, and the address SHALL be phys_row*COLS + cursor_col.
REQ-018 For a printable character (0x20..0x7E), wr_en, wr_addr and wr_data SHALL be registered on the accept edge, so wr_en is high for exactly the next cycle with the pre-advance cursor address; back-to-back printable characters SHALL sustain one character per cycle.
REQ-019 After a printable character, cursor_col SHALL increment; at COLS-1 it SHALL wrap to 0 and perform a newline.
REQ-020 LF (0x0A) SHALL set cursor_col to 0 and perform a newline, with no RAM write.
REQ-021 CR (0x0D) SHALL set cursor_col to 0, with no RAM write.
REQ-022 Any other code SHALL be consumed without a RAM write or cursor change.
REQ-023 On a newline with cursor_row < ROWS-1, cursor_row SHALL increment.
REQ-024 On a newline with cursor_row = ROWS-1, scroll_base SHALL increment mod ROWS, cursor_row SHALL stay at ROWS-1, and the FSM SHALL go to SCROLL_CLR.
REQ-025 SCROLL_CLR SHALL write 0x20 to the COLS addresses of the new bottom physical row, one per cycle in ascending column order, then return to IDLE; in_ready SHALL be low for exactly COLS cycles.
REQ-026 INIT_CLR SHALL write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, then enter IDLE.
REQ-027 When a printable character lands at row ROWS-1, column COLS-1, its write SHALL occur first, and the scroll clear SHALL follow in the next COLS cycles.
REQ-028 wr_en SHALL be low in every cycle with no write pending.

Reset
REQ-029 While rst is high, the block SHALL hold state INIT_CLR, a clear counter of 0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, cursor_row=0, cursor_col=0 and scroll_base=0.
REQ-030 Reset asserted mid-scroll or mid-init SHALL abandon the operation and restart the full INIT_CLR on release.

Configuration
REQ-031 With macro VGA_TERM_BS_EN defined, BS (0x08) SHALL move cursor_col back by one (no move at column 0, no row change) and write 0x20 at the new position.
REQ-032 Without VGA_TERM_BS_EN, 0x08 SHALL be consumed like any other non-printable code.

Structure
REQ-033 Package vga_term_pkg SHALL hold the state enum and the ASCII constants CH_LF, CH_CR, CH_BS and CH_SPACE.
REQ-034 Address mapping SHALL be one combinational sub-module, vga_term_addr (inputs row, col, base; output addr), instantiated for both the cursor and the clear paths.

Verification
REQ-035 Release reset: wr_en high for 2100 consecutive cycles at addresses 0..2099 with data 0x20, then in_ready=1, cursor (0,0), scroll_base 0.
REQ-036 Send "AB" back-to-back: writes 0x41@0 then 0x42@1 on consecutive cycles; cursor_col=2.
REQ-037 Send 'x', then CR, then LF: one write 0x78@0; cursor ends at (1,0); CR and LF produce no writes.
REQ-038 Cursor at (29,69) with scroll_base 0, send 'Z': write 0x5A@2099; scroll_base=1; 70 writes of 0x20 at addresses 0..69; in_ready low for those 70 cycles; cursor at (29,0).
REQ-039 Assert rst at cycle 30 of a scroll clear: after release, the full 2100-cycle init clear runs and all outputs return to reset values.
REQ-040 With VGA_TERM_BS_EN, cursor (0,5), send 0x08: write 0x20@4 and cursor_col=4; BS at column 0 writes 0x20@0 and the cursor stays at (0,0); without the macro, no write occurs.
